mem_port_arbiter: RTL

- Shares one single-port synchronous word RAM between the instruction-fetch requester (PC side) and the data requester (load/store side).
- Issues at most one RAM access per cycle and returns read data to the owning requester after a fixed RAM latency.
- Data has priority by default; a run-length limit guarantees fetch is never starved.
- Sits between the CPU core and the RAM, replacing the separate instruction/data paths.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter_lat_pipe.sv | 39 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and widths for the CPU memory port arbiter
package cpu_mem_pkg;

  localparam int RAM_LAT_MAX = 4;
  localparam int WORD_W      = 32;
  localparam int BE_W        = WORD_W / 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } lat_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and RAM signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10
);
  import cpu_mem_pkg::*;

  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ack;
  logic              i_rvalid;
  logic [WORD_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [BE_W-1:0]   d_be;
  logic [31:0]       d_addr;
  logic [WORD_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_rvalid;
  logic [WORD_W-1:0] d_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [BE_W-1:0]   ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;

  logic              busy;

  // slave: the arbiter; master: the core requesters and the RAM around it
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata, busy
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, ram_rdata,
    input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
           ram_en, ram_we, ram_be, ram_addr, ram_wdata, busy
  );

endinterface

// File: rtl/mem_port_arbiter_lat_pipe.sv
// rtl/mem_port_arbiter_lat_pipe.sv - RAM_LAT-deep owner tag pipe tracking reads in flight
module mem_arb_lat_pipe
  import cpu_mem_pkg::*;
#(
  parameter int RAM_LAT = 1
) (
  input  logic     clk_cpu,
  input  logic     reset,
  input  lat_tag_t tag_in,
  output lat_tag_t tag_out,
  output logic     any_valid
);

  lat_tag_t stage_q [RAM_LAT];

  // Reset empties every stage so no pre-reset read can ever surface.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < RAM_LAT; k++) begin
        stage_q[k] <= '{valid: 1'b0, owner: OWN_NONE};
      end
    end else begin
      stage_q[0] <= tag_in;
      for (int k = 1; k < RAM_LAT; k++) begin
        stage_q[k] <= stage_q[k-1];
      end
    end
  end

  assign tag_out = stage_q[RAM_LAT-1];

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < RAM_LAT; k++) begin
      any_valid = any_valid | stage_q[k].valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between fetch and data; MEM_PORT_ARB_PERF_EN adds stall counters
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int RAM_LAT   = 1,
  parameter int MAX_D_RUN = 4
) (
  input  logic                clk_cpu,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
`ifdef MEM_PORT_ARB_PERF_EN
  ,
  output logic [31:0]         i_stall_cnt,
  output logic [31:0]         d_stall_cnt
`endif
);

  localparam logic [3:0] RUN_MAX = 4'(MAX_D_RUN);

  logic [3:0]        run_cnt;
  logic              grant_i;
  logic              grant_d;
  owner_t            own;
  lat_tag_t          tag_in;
  lat_tag_t          tag_out;
  logic              pipe_busy;
  logic              i_ret;
  logic              d_ret;
  logic [WORD_W-1:0] i_rdata_q;
  logic [WORD_W-1:0] d_rdata_q;
  logic              unused_addr_bits;

  // Data wins unless it has already taken MAX_D_RUN grants in a row past a waiting fetch.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    own     = OWN_NONE;
    if (!reset) begin
      if (bus.d_req && !(bus.i_req && run_cnt == RUN_MAX)) begin
        grant_d = 1'b1;
        own     = OWN_D;
      end else if (bus.i_req) begin
        grant_i = 1'b1;
        own     = OWN_I;
      end
    end
  end

  assign bus.i_ack = grant_i;
  assign bus.d_ack = grant_d;

  always_comb begin
    bus.ram_en    = grant_i | grant_d;
    bus.ram_we    = 1'b0;
    bus.ram_be    = '0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (grant_d) begin
      bus.ram_we    = bus.d_we;
      bus.ram_be    = bus.d_we ? bus.d_be : {BE_W{1'b1}};
      bus.ram_addr  = bus.d_addr[ADDR_W+1:2];
      bus.ram_wdata = bus.d_wdata;
    end else if (grant_i) begin
      bus.ram_be    = {BE_W{1'b1}};
      bus.ram_addr  = bus.i_addr[ADDR_W+1:2];
    end
  end

  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (!bus.i_req || grant_i) begin
      run_cnt <= '0;
    end else if (grant_d && run_cnt != RUN_MAX) begin
      run_cnt <= run_cnt + 4'd1;
    end
  end

  assign tag_in = '{valid: grant_i | (grant_d & ~bus.d_we), owner: own};

  mem_arb_lat_pipe #(
    .RAM_LAT (RAM_LAT)
  ) u_lat_pipe (
    .clk_cpu   (clk_cpu),
    .reset     (reset),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (pipe_busy)
  );

  assign i_ret = tag_out.valid && (tag_out.owner == OWN_I);
  assign d_ret = tag_out.valid && (tag_out.owner == OWN_D);

  // Returning data is passed straight through, then held for that owner.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (i_ret) i_rdata_q <= bus.ram_rdata;
      if (d_ret) d_rdata_q <= bus.ram_rdata;
    end
  end

  assign bus.i_rvalid = i_ret;
  assign bus.d_rvalid = d_ret;
  assign bus.i_rdata  = i_ret ? bus.ram_rdata : i_rdata_q;
  assign bus.d_rdata  = d_ret ? bus.ram_rdata : d_rdata_q;
  assign bus.busy     = pipe_busy;

`ifdef MEM_PORT_ARB_PERF_EN
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      i_stall_cnt <= '0;
      d_stall_cnt <= '0;
    end else begin
      if (bus.i_req && !grant_i) i_stall_cnt <= i_stall_cnt + 32'd1;
      if (bus.d_req && !grant_d) d_stall_cnt <= d_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
